// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter
// Packet-aware round-robin arbiter that shares one registered beat stage
// between NUM_REQ requesters. A requester that starts a packet keeps the
// stage until its beat carrying last has been accepted; after that it
// drops to the lowest priority for the next packet.
//
// Handshake (both sides): a beat moves on a rising edge where valid and
// ready are both high. The upstream side sees req_ready[i], which is high
// only for the single granted requester and only when the output register
// can take a beat this cycle; req_ready never looks at req_ready itself and
// may be high while the granted requester is not valid. The downstream side
// sees out_valid/out_data/out_last/out_src straight from flops; once
// out_valid is high those fields stay frozen until out_ready is sampled
// high, and out_ready reaches none of them combinationally.

module rr_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output logic [ID_W-1:0]           out_src,
    input  logic                      out_ready,
    output logic                      locked
);

    // Two-state packet FSM; 'locked' is the externally visible copy of it.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]         state;
    logic [0:0]         state_next;

    // Index of the most recently granted requester. While LOCKED it is the
    // packet owner, so no separate owner register is needed.
    logic [ID_W-1:0]    last_grant;

    logic               load_en;
    logic               grant_any;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_last;
    logic               xfer;

    // Index 'offset' places after 'base', wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return ID_W'(sum);
    endfunction

    // The output register can accept a beat when empty or when it drains now.
    assign load_en = !out_valid || out_ready;

    // Grant selection: the owner while locked, otherwise the first valid
    // requester after last_grant. Walking from the farthest candidate to the
    // nearest lets the nearest valid one overwrite the others.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = last_grant;
        if (state == ST_LOCKED) begin
            grant_any = 1'b1;
            grant_idx = last_grant;
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                if (req_valid[rr_index(last_grant, k)]) begin
                    grant_any = 1'b1;
                    grant_idx = rr_index(last_grant, k);
                end
            end
        end
    end

    // One-hot grant vector plus the granted requester's data and last flag.
    always_comb begin
        grant    = '0;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant[i] = grant_any;
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_last = req_last[i];
            end
        end
    end

    assign req_ready = load_en ? grant : '0;
    assign xfer      = |(req_valid & req_ready);

    // Packet FSM next state: a non-last beat opens a packet, the owner's
    // last beat closes it, a single-beat packet leaves the FSM in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (xfer && !sel_last) begin
                    state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (xfer && sel_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset drops any packet in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign locked = (state == ST_LOCKED);

    // Priority pointer follows every accepted beat, so after a packet the
    // sender sits at the bottom of the rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (xfer) begin
            last_grant <= grant_idx;
        end
    end

    // Output register: load on transfer, empty when drained with nothing
    // new, hold every field while downstream is stalling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (load_en) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_src   <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter
// Table-driven bench for rr_stream_arbiter (NUM_REQ=4, DATA_W=8). Each
// record gives one cycle of inputs plus the expected req_ready and locked;
// accepted beats go into an expected queue and are compared when they show
// up on the output register. Reset-related cases are hand-written.

module tb_rr_stream_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        locked;

    rr_stream_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .locked    (locked)
    );

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_lock;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] exp_q[$];   // {last, src[1:0], data[7:0]}
    logic        ov_prev;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                       input logic [3:0] rdy, input logic lk, input int sel,
                       input logic [7:0] val);
        vec_t t;
        t.v        = v;
        t.l        = l;
        t.d        = $urandom();
        if (sel >= 0) t.d[sel*8 +: 8] = val;
        t.ordy     = ordy;
        t.exp_rdy  = rdy;
        t.exp_lock = lk;
        vecs.push_back(t);
    endtask

    // Reset with idle inputs; returns one time unit after a rising edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;
        exp_q.delete();
        ov_prev   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Driver: called one time unit after a rising edge; applies one record,
    // checks req_ready and the output beat mid-cycle, then checks the
    // registered state just after the next edge.
    task automatic drive_cycle(input vec_t vv);
        logic [10:0] e;
        logic        xfer_exp;
        logic        ov_next;
        req_valid = vv.v;
        req_last  = vv.l;
        req_data  = vv.d;
        out_ready = vv.ordy;
        #3;
        check("req_ready", {28'd0, req_ready}, {28'd0, vv.exp_rdy});
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_beat: got src %0d data 0x%0h, expected no beat", out_src, out_data);
            end else begin
                e = exp_q[0];
                check("sb_data", {24'd0, out_data}, {24'd0, e[7:0]});
                check("sb_src",  {30'd0, out_src},  {30'd0, e[9:8]});
                check("sb_last", {31'd0, out_last}, {31'd0, e[10]});
                if (vv.ordy) void'(exp_q.pop_front());
            end
        end
        xfer_exp = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (vv.exp_rdy[i] && vv.v[i]) begin
                exp_q.push_back({vv.l[i], 2'(i), vv.d[i*8 +: 8]});
                xfer_exp = 1'b1;
            end
        end
        ov_next = xfer_exp || (ov_prev && !vv.ordy);
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, ov_next});
        check("locked",    {31'd0, locked},    {31'd0, vv.exp_lock});
        ov_prev = ov_next;
    endtask

    task automatic idle_cycle();
        vec_t t;
        t.v = 4'b0000; t.l = 4'b0000; t.d = 32'd0;
        t.ordy = 1'b1; t.exp_rdy = 4'b0000; t.exp_lock = 1'b0;
        drive_cycle(t);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t t;

        // Reset values, observed before any clock edge.
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;
        ov_prev   = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        check("rst_out_last",  {31'd0, out_last},  32'd0);
        check("rst_out_src",   {30'd0, out_src},   32'd0);
        check("rst_locked",    {31'd0, locked},    32'd0);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        do_reset();

        // Single requester 2, single-beat packet 0x5A.
        t.v = 4'b0100; t.l = 4'b0100; t.d = $urandom(); t.d[23:16] = 8'h5A;
        t.ordy = 1'b1; t.exp_rdy = 4'b0100; t.exp_lock = 1'b0;
        drive_cycle(t);
        check("single_data", {24'd0, out_data}, 32'h5A);
        check("single_src",  {30'd0, out_src},  32'd2);
        check("single_last", {31'd0, out_last}, 32'd1);
        idle_cycle();

        // Round robin from a fresh pointer: 0,1,2,3,0,1,2,3 with no bubbles.
        for (int k = 0; k < 8; k++) begin
            add(4'b1111, 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b0, -1, 8'h00);
        end
        // Packet lock: 0 wins first, then 1 holds the stage for 3 beats
        // while 0 and 3 keep requesting; afterwards 3, then 0.
        add(4'b1011, 4'b1001, 1'b1, 4'b0001, 1'b0, -1, 8'h00);
        add(4'b1011, 4'b1001, 1'b1, 4'b0010, 1'b1,  1, 8'h11);
        add(4'b1011, 4'b1001, 1'b1, 4'b0010, 1'b1,  1, 8'h12);
        add(4'b1011, 4'b1011, 1'b1, 4'b0010, 1'b0,  1, 8'h13);
        add(4'b1011, 4'b1001, 1'b1, 4'b1000, 1'b0, -1, 8'h00);
        add(4'b1011, 4'b1001, 1'b1, 4'b0001, 1'b0, -1, 8'h00);
        // Backpressure: 0xC3 held for 5 stalled cycles, then drained in the
        // same cycle that requester 0 loads.
        add(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0,  2, 8'hC3);
        for (int k = 0; k < 5; k++) begin
            add(4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, -1, 8'h00);
        end
        add(4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b0, -1, 8'h00);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, -1, 8'h00);
        // Owner stall: 2 opens a packet, goes quiet for 4 cycles while 0
        // waits, then finishes; 0 is served next.
        add(4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, -1, 8'h00);
        for (int k = 0; k < 4; k++) begin
            add(4'b0001, 4'b0001, 1'b1, 4'b0100, 1'b1, -1, 8'h00);
        end
        add(4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b0, -1, 8'h00);
        add(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b0, -1, 8'h00);
        add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, -1, 8'h00);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i]);
        end

        // Asynchronous reset in the middle of a packet from requester 1.
        t.v = 4'b0010; t.l = 4'b0000; t.d = $urandom();
        t.ordy = 1'b1; t.exp_rdy = 4'b0010; t.exp_lock = 1'b1;
        drive_cycle(t);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_locked",    {31'd0, locked},    32'd0);
        check("midrst_out_src",   {30'd0, out_src},   32'd0);
        check("midrst_out_data",  {24'd0, out_data},  32'd0);
        req_valid = '0;
        req_last  = '0;
        exp_q.delete();
        ov_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Four-way contention after reset: 0 first, then 1.
        t.v = 4'b1111; t.l = 4'b1111; t.d = $urandom();
        t.ordy = 1'b1; t.exp_rdy = 4'b0001; t.exp_lock = 1'b0;
        drive_cycle(t);
        t.d = $urandom(); t.exp_rdy = 4'b0010;
        drive_cycle(t);
        idle_cycle();
        idle_cycle();

        check("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
